sdram_arbiter: RTL and testbench

Shares the single byte-wide CPU/chipset port of the SDRAM controller between NREQ requesters, e.g. the loader, Z80 CPU and FDC DMA. It picks one requester, latches its address, data, bank and direction, and raises the controller's `oe`/`we` exactly at a controller slot start. It holds the strobe for one full slot, returns read data, and acks the requester. The block sits between the requesters and the controller's `addr`/`din`/`dout`/`oe`/`we`/`bank` port, in the SDRAM clock domain.

---
 rtl/sdram_arb_pkg.sv | 7 +
 rtl/sdram_arb_pick.sv | 33 +++
 rtl/sdram_arbiter.sv | 128 ++++++++++++
 tb/tb_sdram_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and sizing constants for the SDRAM port arbiter
package sdram_arb_pkg;
  localparam int AW_DEFAULT = 23;
  localparam int MAX_NREQ = 4;
  localparam int IW = $clog2(MAX_NREQ);
  typedef enum logic [1:0] {IDLE, ARMED, BUSY} state_t;
endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational grant picker; SDRAM_ARB_RR_EN rotates requesters 1..NREQ-1 behind fixed-priority 0
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] elig,
`ifdef SDRAM_ARB_RR_EN
  input  logic [IW-1:0]   ptr,
`endif
  output logic [IW-1:0]   idx,
  output logic            valid
);
  // lowest eligible index wins, or the first eligible one at or after the rotating pointer
  always_comb begin
    int off;
    int j;
    off = 0;
    j = 0;
    idx = '0;
    valid = |elig;
`ifdef SDRAM_ARB_RR_EN
    off = (ptr == '0) ? 0 : int'(ptr) - 1;
    for (int k = NREQ - 2; k >= 0; k--) begin
      j = 1 + (off + k) % (NREQ - 1);
      if (elig[j]) idx = IW'(j);
    end
    if (elig[0]) idx = '0;
`else
    for (int k = NREQ - 1; k >= 0; k--) if (elig[k]) idx = IW'(k);
`endif
  end
endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: slot-aligned sharing of the byte-wide SDRAM controller port; SDRAM_ARB_RR_EN enables round-robin
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = AW_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slot,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  wr,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*8-1:0] din,
  input  logic [NREQ*2-1:0] bank,
  output logic [NREQ-1:0]  ack,
  output logic [7:0]       rdata,
  output logic [AW-1:0]    mem_addr,
  output logic [7:0]       mem_din,
  output logic [1:0]       mem_bank,
  output logic             mem_oe,
  output logic             mem_we,
  input  logic [7:0]       mem_dout
);
  state_t state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, pick_idx;
  logic pick_valid, wr_q, wr_d, oe_q, oe_d, we_q, we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_din_q, mem_din_d, rdata_q, rdata_d;
  logic [1:0] mem_bank_q, mem_bank_d;
  logic [NREQ-1:0] ack_q, ack_d;
`ifdef SDRAM_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
`endif

  sdram_arb_pick #(.NREQ(NREQ)) u_pick (
    .elig  (req & ~ack_q),
`ifdef SDRAM_ARB_RR_EN
    .ptr   (ptr_q),
`endif
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // grant in IDLE, raise the strobe on the next slot, drop it and ack on the slot after
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wr_d = wr_q;
    mem_addr_d = mem_addr_q;
    mem_din_d = mem_din_q;
    mem_bank_d = mem_bank_q;
    oe_d = oe_q;
    we_d = we_q;
    rdata_d = rdata_q;
    ack_d = '0;
`ifdef SDRAM_ARB_RR_EN
    ptr_d = ptr_q;
`endif
    case (state_q)
      IDLE: if (pick_valid) begin
        state_d = ARMED;
        grant_d = pick_idx;
        wr_d = wr[pick_idx];
        mem_addr_d = addr[pick_idx*AW +: AW];
        mem_din_d = din[pick_idx*8 +: 8];
        mem_bank_d = bank[pick_idx*2 +: 2];
`ifdef SDRAM_ARB_RR_EN
        if (pick_idx != '0) ptr_d = (pick_idx == IW'(NREQ - 1)) ? IW'(1) : pick_idx + 1'b1;
`endif
      end
      ARMED: if (slot) begin
        state_d = BUSY;
        oe_d = ~wr_q;
        we_d = wr_q;
      end
      BUSY: if (slot) begin
        state_d = IDLE;
        oe_d = 1'b0;
        we_d = 1'b0;
        rdata_d = wr_q ? rdata_q : mem_dout;
        ack_d = NREQ'(1) << grant_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and port registers; reset abandons any in-flight access without an ack
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      wr_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q <= '0;
      mem_bank_q <= '0;
      oe_q <= 1'b0;
      we_q <= 1'b0;
      rdata_q <= '0;
      ack_q <= '0;
`ifdef SDRAM_ARB_RR_EN
      ptr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wr_q <= wr_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q <= mem_din_d;
      mem_bank_q <= mem_bank_d;
      oe_q <= oe_d;
      we_q <= we_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
`ifdef SDRAM_ARB_RR_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign ack = ack_q;
  assign rdata = rdata_q;
  assign mem_addr = mem_addr_q;
  assign mem_din = mem_din_q;
  assign mem_bank = mem_bank_q;
  assign mem_oe = oe_q;
  assign mem_we = we_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized checks of sdram_arbiter against a transaction-level model
module tb_sdram_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 23;
  localparam int P = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic slot;
  logic [NREQ-1:0] req = '0, wr = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*8-1:0] din = '0;
  logic [NREQ*2-1:0] bank = '0;
  logic [NREQ-1:0] ack;
  logic [7:0] rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic [1:0] mem_bank;
  logic mem_oe, mem_we;
  logic ovr_en = 1'b0;
  logic [7:0] dout_ovr = 8'h00;
  logic [7:0] exp_rdata = 8'h00;
  int cyc = 0;
  int total = 0, passed = 0, fails = 0;
`ifdef SDRAM_ARB_RR_EN
  int ptr_m = 0;
`endif

  sdram_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk(clk), .reset(reset), .slot(slot), .req(req), .wr(wr), .addr(addr), .din(din), .bank(bank),
    .ack(ack), .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_bank(mem_bank),
    .mem_oe(mem_oe), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign slot = (cyc % P) == P - 1;

  function automatic logic [7:0] mem_f(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
  endfunction
  assign mem_dout = ovr_en ? dout_ovr : mem_f(mem_addr);

  function automatic int pick(input logic [NREQ-1:0] e);
`ifdef SDRAM_ARB_RR_EN
    int s;
    if (e[0]) return 0;
    s = (ptr_m == 0) ? 1 : ptr_m;
    for (int k = 0; k < NREQ - 1; k++) if (e[1 + (s - 1 + k) % (NREQ - 1)]) return 1 + (s - 1 + k) % (NREQ - 1);
`else
    for (int j = 0; j < NREQ; j++) if (e[j]) return j;
`endif
    return -1;
  endfunction

  task automatic note_grant(input int j);
`ifdef SDRAM_ARB_RR_EN
    if (j >= 1) ptr_m = (j == NREQ - 1) ? 1 : j + 1;
`endif
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [7:0] d, input logic [1:0] b);
    wr[i] = w;
    addr[i*AW +: AW] = a;
    din[i*8 +: 8] = d;
    bank[i*2 +: 2] = b;
    req[i] = 1'b1;
  endtask

  task automatic single(input string tag, input int i, input logic w, input logic [AW-1:0] a,
                        input logic [7:0] d, input logic [1:0] b, input bit drop_early);
    int n, hi, acks;
    bit stable, aligned;
    n = 0; hi = 0; acks = 0; stable = 1'b1; aligned = 1'b0;
    set_req(i, w, a, d, b);
    note_grant(i);
    while (ack == '0 && n < 3*P + 4) begin
      tick();
      n++;
      if (drop_early && n == 1) req[i] = 1'b0;
      if (mem_oe || mem_we) begin
        if (hi == 0) aligned = (cyc % P) == 0;
        hi++;
        if (mem_addr !== a || mem_bank !== b || (w && mem_din !== d) || mem_we !== w || mem_oe !== !w) stable = 1'b0;
      end
    end
    if (!w) exp_rdata = ovr_en ? dout_ovr : mem_f(a);
    check({tag, ":ack"}, ack, 1 << i);
    check({tag, ":rdata"}, rdata, exp_rdata);
    check({tag, ":strobe_len"}, hi, P);
    check({tag, ":slot_aligned"}, aligned, 1);
    check({tag, ":operands_stable"}, stable, 1);
    check({tag, ":latency_in_range"}, (n >= P + 2 && n <= 2*P + 2), 1);
    if (!drop_early) req[i] = 1'b0;
    repeat (2*P) begin
      tick();
      if (ack != '0) acks++;
    end
    check({tag, ":no_extra_ack"}, acks, 0);
  endtask

  task automatic multi(input string tag, input logic [NREQ-1:0] m, input int nacks, input bit hold);
    logic [NREQ-1:0] pend;
    logic [AW-1:0] sa;
    logic sw;
    int e, n, got;
    sa = 'x; sw = 1'bx;
    for (int j = 0; j < NREQ; j++)
      if (m[j]) set_req(j, 1'($urandom), AW'($urandom), 8'($urandom), 2'($urandom));
    pend = m; e = pick(pend); note_grant(e); got = 0; n = 0;
    while (got < nacks && e >= 0 && n < (nacks + 1) * (3*P + 4)) begin
      tick();
      n++;
      if (mem_oe || mem_we) begin
        sa = mem_addr;
        sw = mem_we;
      end
      if (ack != '0) begin
        check({tag, ":ack_order"}, ack, 1 << e);
        check({tag, ":op"}, {sw, sa}, {wr[e], addr[e*AW +: AW]});
        if (!wr[e]) exp_rdata = mem_f(addr[e*AW +: AW]);
        check({tag, ":rdata"}, rdata, exp_rdata);
        got++;
        if (!hold) begin
          pend[e] = 1'b0;
          req[e] = 1'b0;
        end
        if (got < nacks) begin
          e = pick(pend & ~(NREQ'(1) << e));
          if (e >= 0) note_grant(e);
        end
      end
    end
    req = '0;
    check({tag, ":ack_count"}, got, nacks);
    repeat (2*P) tick();
  endtask

  initial begin
    int n, acks, r1, r2, lowc;
    logic prev_oe;
    logic [AW-1:0] cur_a;
    logic [NREQ-1:0] m;
    repeat (3) tick();
    check("reset:ack", ack, 0);
    check("reset:oe_we", {mem_oe, mem_we}, 0);
    check("reset:rdata", rdata, 0);
    check("reset:mem_port", {mem_addr, mem_din, mem_bank}, 0);
    reset = 1'b0;
    tick();

    ovr_en = 1'b1; dout_ovr = 8'hA5;
    single("read_r1", 1, 1'b0, 23'h012345, 8'h00, 2'd0, 1'b0);
    ovr_en = 1'b0;
    single("write_r2", 2, 1'b1, 23'h00BEEF, 8'h3C, 2'd2, 1'b0);
    single("drop_armed", 0, 1'b0, 23'h055AA0, 8'h00, 2'd1, 1'b1);

    multi("all_three", 3'b111, 3, 1'b0);
    multi("held_1_2", 3'b110, 4, 1'b1);

    cur_a = 23'h000100;
    set_req(1, 1'b0, cur_a, 8'h00, 2'd1);
    note_grant(1);
    n = 0; acks = 0; r1 = -1; r2 = -1; lowc = 0; prev_oe = 1'b0;
    while (acks < 2 && n < 8*P) begin
      tick();
      n++;
      if (mem_oe && !prev_oe) begin
        if (r1 < 0) r1 = n;
        else r2 = n;
      end
      if (!mem_oe && r1 >= 0 && r2 < 0) lowc++;
      if (ack[1]) begin
        acks++;
        check("b2b:rdata", rdata, mem_f(cur_a));
        if (acks == 1) begin
          cur_a = 23'h000200;
          addr[AW +: AW] = cur_a;
          note_grant(1);
        end
      end
      prev_oe = mem_oe;
    end
    req[1] = 1'b0;
    check("b2b:acks", acks, 2);
    check("b2b:rise_spacing", r2 - r1, 2*P);
    check("b2b:oe_low_between", lowc >= 1, 1);
    repeat (2*P) tick();

    set_req(1, 1'b0, 23'h0ABCDE, 8'h00, 2'd3);
    note_grant(1);
    n = 0;
    while (!mem_oe && n < 3*P) begin
      tick();
      n++;
    end
    check("rst_busy:oe_seen", mem_oe, 1);
    tick();
    reset = 1'b1;
    req = '0;
    tick();
    reset = 1'b0;
    check("rst_busy:oe", mem_oe, 0);
    check("rst_busy:ack", ack, 0);
    check("rst_busy:regs", {rdata, mem_addr, mem_bank}, 0);
    exp_rdata = 8'h00;
`ifdef SDRAM_ARB_RR_EN
    ptr_m = 0;
`endif
    acks = 0;
    repeat (3*P) begin
      tick();
      if (ack != '0) acks++;
    end
    check("rst_busy:no_ack", acks, 0);
    single("after_reset", 1, 1'b0, 23'h000777, 8'h00, 2'd0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      multi("random", m, $countones(m), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
